// File: rtl/mfcc_pkg.sv
// Shared MFCC pipeline types and widths.
// Log-frame buffer FSM states live here.
package mfcc_pkg;
  localparam int LOG_W = 16;
  localparam int E_W = 46;
  localparam int NUM_FILT_DEF = 20;
  localparam int AW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    W1,
    W2
  } state_t;
endpackage

// File: rtl/log_bank.sv
// Ping-pong pair of log-value banks.
// One write port, one comb read port, sum per bank.
module log_bank
  import mfcc_pkg::*;
#(
  parameter int NUM_FILT = 20,
  parameter int AW = 5,
  parameter int SUM_W = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             wsel,
  input  logic [AW-1:0]    waddr,
  input  logic [LOG_W-1:0] wdata,
  input  logic             sum_we,
  input  logic [SUM_W-1:0] sum_wdata,
  input  logic             rsel,
  input  logic [AW-1:0]    raddr,
  output logic [LOG_W-1:0] rdata,
  output logic [SUM_W-1:0] rsum
);
  logic [LOG_W-1:0] mem [2][2**AW];
  logic [SUM_W-1:0] sum [2];

  // Bank storage and frame sums; cleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        sum[b] <= '0;
        for (int i = 0; i < 2**AW; i++)
          mem[b][i] <= '0;
      end
    end else begin
      if (we)
        mem[wsel][waddr] <= wdata;
      if (sum_we)
        sum[wsel] <= sum_wdata;
    end
  end

  // Out-of-range addresses read as zero.
  always_comb begin
    rdata = '0;
    if (int'(raddr) < NUM_FILT)
      rdata = mem[rsel][raddr];
    rsum = sum[rsel];
  end
endmodule

// File: rtl/log_frame_buf.sv
// Sequences energies through the log stage and
// gathers log values into ping-pong frames.
module log_frame_buf
  import mfcc_pkg::*;
#(
  parameter int NUM_FILT = NUM_FILT_DEF,
  parameter int AW = AW_DEF,
  parameter int SUM_W = LOG_W + AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [E_W-1:0]   e_in,
  input  logic             e_valid,
  output logic             e_ready,
  output logic [E_W-1:0]   log_in,
  output logic             log_en,
  input  logic [LOG_W-1:0] log_out,
  input  logic             log_overf,
  output logic             frame_valid,
  input  logic [AW-1:0]    frame_addr,
  output logic [LOG_W-1:0] frame_data,
  output logic [SUM_W-1:0] frame_sum,
  input  logic             frame_done,
  output logic             eos
);
  state_t state, state_n;
  logic [AW-1:0] count;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] sum_next;
  logic wr_bank, rd_bank;
  logic [1:0] full;
  logic ov;
  logic wr, last, done_ok;

  assign last = count == AW'(NUM_FILT - 1);
  assign sum_next = acc + SUM_W'(log_out);
  assign done_ok = frame_done && full[rd_bank];
  assign frame_valid = full[rd_bank];

  // Next state and per-state strobes.
  always_comb begin
    state_n = state;
    e_ready = 1'b0;
    log_en = 1'b0;
    eos = 1'b0;
    wr = 1'b0;
    unique case (state)
      IDLE: begin
        e_ready = !full[wr_bank] && !reset;
        if (e_valid && e_ready)
          state_n = ISSUE;
      end
      ISSUE: begin
        log_en = 1'b1;
        state_n = W1;
      end
      W1: state_n = W2;
      W2: begin
        eos = ov;
        wr = !ov;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Request latch, frame fill counters and bank flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      log_in <= '0;
      ov <= 1'b0;
      count <= '0;
      acc <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full <= '0;
    end else begin
      if (state == IDLE && e_valid && e_ready)
        log_in <= e_in;
      if (state == W1)
        ov <= log_overf;
      if (state == W2 && ov) begin
        count <= '0;
        acc <= '0;
      end
      if (wr) begin
        if (last) begin
          full[wr_bank] <= 1'b1;
          wr_bank <= !wr_bank;
          count <= '0;
          acc <= '0;
        end else begin
          count <= count + 1'b1;
          acc <= sum_next;
        end
      end
      if (done_ok) begin
        full[rd_bank] <= 1'b0;
        rd_bank <= !rd_bank;
      end
    end
  end

  log_bank #(
    .NUM_FILT(NUM_FILT),
    .AW(AW),
    .SUM_W(SUM_W)
  ) u_bank (
    .clk(clk),
    .reset(reset),
    .we(wr),
    .wsel(wr_bank),
    .waddr(count),
    .wdata(log_out),
    .sum_we(wr && last),
    .sum_wdata(sum_next),
    .rsel(rd_bank),
    .raddr(frame_addr),
    .rdata(frame_data),
    .rsum(frame_sum)
  );
endmodule

// File: tb/tb_log_frame_buf.sv
// Randomized bench for log_frame_buf with
// a log-stage stub and frame queue model.
module tb_log_frame_buf;
  import mfcc_pkg::*;
  localparam int NF = 20;
  localparam int AW = 5;
  localparam int SW = 21;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [45:0] e_in = '0;
  logic e_valid = 1'b0;
  logic e_ready;
  logic [45:0] log_in;
  logic log_en;
  logic [15:0] log_out = '0;
  logic log_overf = 1'b0;
  logic frame_valid;
  logic [AW-1:0] frame_addr = '0;
  logic [15:0] frame_data;
  logic [SW-1:0] frame_sum;
  logic frame_done = 1'b0;
  logic eos;

  always #5 clk = ~clk;

  log_frame_buf #(.NUM_FILT(NF), .AW(AW), .SUM_W(SW)) dut (
    .clk(clk),
    .reset(reset),
    .e_in(e_in),
    .e_valid(e_valid),
    .e_ready(e_ready),
    .log_in(log_in),
    .log_en(log_en),
    .log_out(log_out),
    .log_overf(log_overf),
    .frame_valid(frame_valid),
    .frame_addr(frame_addr),
    .frame_data(frame_data),
    .frame_sum(frame_sum),
    .frame_done(frame_done),
    .eos(eos)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int eos_seen = 0;
  int eos_exp = 0;
  int en_seen = 0;
  logic [45:0] req = '0;
  int ph = 0;

  typedef logic [15:0] frame_t [NF];
  frame_t fq[$];
  int fsum[$];
  logic [15:0] part[$];

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, obs, exp);
    end
  endtask

  // Mitchell-style log2(e)*512 approximation.
  function automatic logic [15:0] stub(input logic [45:0] e);
    int m;
    longint unsigned x, fr;
    if (e == 0) return 16'h0;
    m = 0;
    for (int i = 0; i < 46; i++)
      if (e[i]) m = i;
    x = 64'(e);
    fr = ((x - (64'd1 << m)) << 9) >> m;
    return 16'(m * 512 + int'(fr));
  endfunction

  function automatic logic [45:0] rand_e();
    int m;
    logic [63:0] v;
    m = $urandom_range(0, 44);
    v = {$urandom, $urandom};
    v = (v & ((64'd1 << m) - 1)) | (64'd1 << m);
    return 46'(v);
  endfunction

  // Log-stage stub: overf in T+1, result from T+2.
  always @(posedge clk) begin
    #1;
    log_overf = 1'b0;
    if (reset) begin
      ph = 0;
    end else begin
      if (ph == 1) begin
        log_overf = (req == 0);
        ph = 2;
      end else if (ph == 2) begin
        log_out = stub(req);
        ph = 0;
      end
      if (log_en) begin
        req = log_in;
        ph = 1;
        log_out = 16'hdead;
        en_seen++;
      end
      if (eos) eos_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_accept(input logic [45:0] e);
    frame_t f;
    int s;
    if (e == 0) begin
      part.delete();
      eos_exp++;
    end else begin
      part.push_back(stub(e));
      if (part.size() == NF) begin
        s = 0;
        for (int i = 0; i < NF; i++) begin
          f[i] = part[i];
          s += int'(part[i]);
        end
        fq.push_back(f);
        fsum.push_back(s);
        part.delete();
      end
    end
  endtask

  task automatic send(input logic [45:0] e);
    int n;
    n = 0;
    e_in = e;
    e_valid = 1'b1;
    while (!e_ready && n < 100) begin
      cyc(1);
      n++;
    end
    if (!e_ready) begin
      check("send_timeout", 64'(e_ready), 64'd1);
      e_valid = 1'b0;
      return;
    end
    cyc(1);
    e_valid = 1'b0;
    model_accept(e);
  endtask

  task automatic check_frame();
    logic [15:0] want;
    check("fv", 64'(frame_valid), 64'(fq.size() > 0));
    check("ready", 64'(e_ready), 64'(fq.size() < 2));
    if (fq.size() > 0) begin
      for (int a = 0; a <= NF; a++) begin
        frame_addr = AW'(a);
        @(negedge clk);
        want = (a < NF) ? fq[0][a] : 16'h0;
        check("data", 64'(frame_data), 64'(want));
      end
      frame_addr = '1;
      @(negedge clk);
      check("data_hi", 64'(frame_data), 64'd0);
      check("sum", 64'(frame_sum), 64'(fsum[0]));
      frame_addr = '0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_frame();
    frame_done = 1'b1;
    cyc(1);
    frame_done = 1'b0;
    if (fq.size() > 0) begin
      void'(fq.pop_front());
      void'(fsum.pop_front());
    end
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_fv"}, 64'(frame_valid), 64'd0);
    check({tag, "_rdy"}, 64'(e_ready), 64'd0);
    check({tag, "_en"}, 64'(log_en), 64'd0);
    check({tag, "_eos"}, 64'(eos), 64'd0);
    check({tag, "_login"}, 64'(log_in), 64'd0);
    check({tag, "_sum"}, 64'(frame_sum), 64'd0);
    check({tag, "_data"}, 64'(frame_data), 64'd0);
  endtask

  initial begin
    logic [45:0] big;
    int en0, r;
    big = 46'd1 << 44;

    cyc(3);
    check_idle_outs("rst");
    reset = 1'b0;
    cyc(1);
    check("rdy_after_rst", 64'(e_ready), 64'd1);

    send(46'd1);
    for (int i = 1; i < NF; i++) send(big);
    check("lat0", 64'(frame_valid), 64'd0);
    cyc(2);
    check("lat2", 64'(frame_valid), 64'd0);
    cyc(1);
    check("lat3", 64'(frame_valid), 64'd1);
    frame_addr = 5'd0;
    @(negedge clk);
    check("t1_d0", 64'(frame_data), 64'h0);
    frame_addr = 5'd1;
    @(negedge clk);
    check("t1_d1", 64'(frame_data), 64'h5800);
    check("t1_sum", 64'(frame_sum), 64'h68800);
    @(posedge clk);
    #1;
    check_frame();
    release_frame();
    check("t1_fv_fall", 64'(frame_valid), 64'd0);

    for (int i = 0; i < NF; i++) send(46'd3);
    cyc(4);
    check("t2_sum", 64'(frame_sum), 64'h3c00);
    check_frame();
    release_frame();
    check("t2_fv_fall", 64'(frame_valid), 64'd0);

    for (int i = 0; i < 2 * NF; i++) send(rand_e());
    cyc(4);
    check("t3_full", 64'(e_ready), 64'd0);
    check_frame();
    release_frame();
    check("t3_rdy", 64'(e_ready), 64'd1);
    check_frame();
    release_frame();

    for (int i = 0; i < 7; i++) send(rand_e());
    send(46'd0);
    check("eos_i", 64'(eos), 64'd0);
    cyc(1);
    check("eos_w1", 64'(eos), 64'd0);
    cyc(1);
    check("eos_w2", 64'(eos), 64'd1);
    cyc(1);
    check("eos_off", 64'(eos), 64'd0);
    for (int i = 0; i < NF; i++) send(rand_e());
    cyc(4);
    check_frame();
    release_frame();

    for (int i = 0; i < 2 * NF - 1; i++) send(rand_e());
    send(rand_e());
    cyc(2);
    frame_done = 1'b1;
    cyc(1);
    frame_done = 1'b0;
    void'(fq.pop_front());
    void'(fsum.pop_front());
    check("simul_fv", 64'(frame_valid), 64'd1);
    cyc(4);
    check_frame();
    release_frame();
    check("simul_empty", 64'(frame_valid), 64'd0);

    for (int i = 0; i < NF + 1; i++) send(rand_e());
    cyc(1);
    reset = 1'b1;
    #1;
    check_idle_outs("mid");
    cyc(2);
    reset = 1'b0;
    fq.delete();
    fsum.delete();
    part.delete();
    en0 = en_seen;
    cyc(10);
    check("no_en", 64'(en_seen - en0), 64'd0);
    check("post_fv", 64'(frame_valid), 64'd0);
    for (int i = 0; i < NF; i++) send(rand_e());
    cyc(4);
    check_frame();
    release_frame();

    for (int k = 0; k < 300; k++) begin
      if (fq.size() == 2) begin
        cyc(4);
        check_frame();
        release_frame();
      end else begin
        r = $urandom_range(0, 15);
        if (r == 0) send(46'd0);
        else if (r == 1) begin
          cyc(4);
          check_frame();
          release_frame();
        end else send(rand_e());
      end
    end
    cyc(4);
    while (fq.size() > 0) begin
      check_frame();
      release_frame();
    end
    check("eos_count", 64'(eos_seen), 64'(eos_exp));
    check("end_fv", 64'(frame_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
